// File: rtl/cim_datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cim_datapath_seq
//  Description : Compute-in-memory datapath. Owns a bit-line memory array
//                and sequences dual-row logic, shift/unary post-ops, masked
//                reductions and bit-serial transposed addition behind a
//                command/response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cim_datapath_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   sys_clk_in,
   input  logic                   sys_reset_in,
   input  logic                   cmd_valid_in,
   output logic                   cmd_ready_out,
   input  logic [3:0]             cmd_op_in,
   input  logic [1:0]             cmd_func_in,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr_a_in,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr_b_in,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr_d_in,
   input  logic [ADDR_WIDTH-1:0]  cmd_len_in,
   input  logic [SHIFT_WIDTH-1:0] cmd_shift_in,
   input  logic [DATA_WIDTH-1:0]  cmd_data_in,
   output logic                   rsp_valid_out,
   input  logic                   rsp_ready_in,
   output logic [DATA_WIDTH-1:0]  rsp_data_out,
   output logic                   rsp_err_out,
   output logic                   busy_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [3:0] C_OP_WRITE  = 4'd0;
   localparam logic [3:0] C_OP_READ   = 4'd1;
   localparam logic [3:0] C_OP_LOGIC  = 4'd2;
   localparam logic [3:0] C_OP_NOT    = 4'd3;
   localparam logic [3:0] C_OP_SHL    = 4'd4;
   localparam logic [3:0] C_OP_SHR    = 4'd5;
   localparam logic [3:0] C_OP_XORRED = 4'd6;
   localparam logic [3:0] C_OP_ANDRED = 4'd7;
   localparam logic [3:0] C_OP_ADD    = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_EX    = 3'd2,
      ST_CARRY = 3'd3,
      ST_RSP   = 3'd4
   } state_t;

   // Command fields captured at accept; the front end may change its inputs afterwards.
   typedef struct packed {
      logic [3:0]             op;
      logic [1:0]             func;
      logic [ADDR_WIDTH-1:0]  addr_a;
      logic [ADDR_WIDTH-1:0]  addr_b;
      logic [ADDR_WIDTH-1:0]  addr_d;
      logic [ADDR_WIDTH-1:0]  len;
      logic [SHIFT_WIDTH-1:0] shift;
      logic [DATA_WIDTH-1:0]  data;
   } cmd_t;

   state_t                  state_q, state_d;
   cmd_t                    cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0]   k_q, k_d;
   logic [DATA_WIDTH-1:0]   carry_q, carry_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_a_q, rd_b_q;
   logic [ADDR_WIDTH-1:0]   rd_addr_a, rd_addr_b;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   f_val;
   logic [DATA_WIDTH-1:0]   sum_val;

   // Bit-plane k of a transposed operand lives at base+k; addresses wrap.
   assign rd_addr_a = cmd_q.addr_a + k_q;
   assign rd_addr_b = cmd_q.addr_b + k_q;

   // Per-lane bit-line function on the two registered read rows.
   always_comb begin
      f_val = rd_a_q;
      case (cmd_q.func)
         2'd0:    f_val = rd_a_q | rd_b_q;
         2'd1:    f_val = rd_a_q & rd_b_q;
         2'd2:    f_val = rd_a_q ^ rd_b_q;
         default: f_val = rd_a_q;
      endcase
   end

   assign sum_val = rd_a_q ^ rd_b_q ^ carry_q;

   // Sequencer: next state, writeback request and response register updates.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      k_d         = k_q;
      carry_d     = carry_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;
      mem_we      = 1'b0;
      mem_waddr   = cmd_q.addr_d + k_q;
      mem_wdata   = f_val;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_in) begin
               cmd_d   = '{cmd_op_in, cmd_func_in, cmd_addr_a_in, cmd_addr_b_in,
                           cmd_addr_d_in, cmd_len_in, cmd_shift_in, cmd_data_in};
               k_d     = '0;
               carry_d = '0;
               if ((cmd_op_in > C_OP_ADD) ||
                   ((cmd_op_in == C_OP_ADD) && (cmd_len_in == '0))) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
                  state_d     = ST_RSP;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (cmd_q.op == C_OP_WRITE) begin
               mem_we    = 1'b1;
               mem_waddr = cmd_q.addr_d;
               mem_wdata = cmd_q.data;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_EX;
            end
         end
         ST_EX: begin
            state_d = ST_IDLE;
            case (cmd_q.op)
               C_OP_READ: begin
                  rsp_data_d  = rd_a_q;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RSP;
               end
               C_OP_LOGIC: begin
                  mem_we    = 1'b1;
                  mem_wdata = f_val;
               end
               C_OP_NOT: begin
                  mem_we    = 1'b1;
                  mem_wdata = ~f_val;
               end
               C_OP_SHL: begin
                  mem_we    = 1'b1;
                  mem_wdata = f_val << cmd_q.shift;
               end
               C_OP_SHR: begin
                  mem_we    = 1'b1;
                  mem_wdata = f_val >> cmd_q.shift;
               end
               C_OP_XORRED: begin
                  rsp_data_d  = {{(DATA_WIDTH-1){1'b0}}, ^f_val};
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RSP;
               end
               C_OP_ANDRED: begin
                  rsp_data_d  = {{(DATA_WIDTH-1){1'b0}}, &(f_val | ~cmd_q.data)};
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RSP;
               end
               C_OP_ADD: begin
                  mem_we    = 1'b1;
                  mem_wdata = sum_val;
                  carry_d   = (rd_a_q & rd_b_q) | ((rd_a_q ^ rd_b_q) & carry_q);
                  if (k_q == cmd_q.len - 1'b1) begin
                     state_d = ST_CARRY;
                  end else begin
                     k_d     = k_q + 1'b1;
                     state_d = ST_RD;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
         ST_CARRY: begin
            mem_we    = 1'b1;
            mem_waddr = cmd_q.addr_d + cmd_q.len;
            mem_wdata = carry_q;
            state_d   = ST_IDLE;
         end
         ST_RSP: begin
            if (rsp_ready_in) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and response registers; reset aborts any operation in flight.
   always_ff @(posedge sys_clk_in) begin
      if (sys_reset_in) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         carry_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         carry_q     <= carry_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Latched command fields need no reset: they are only consumed after an accept.
   always_ff @(posedge sys_clk_in) begin
      cmd_q <= cmd_d;
   end

   // Memory array: registered dual read, single write suppressed while in reset.
   always_ff @(posedge sys_clk_in) begin
      rd_a_q <= mem_q[rd_addr_a];
      rd_b_q <= mem_q[rd_addr_b];
      if (mem_we && !sys_reset_in) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign cmd_ready_out = (state_q == ST_IDLE);
   assign busy_out      = (state_q != ST_IDLE);
   assign rsp_valid_out = rsp_valid_q;
   assign rsp_err_out   = rsp_err_q;
   assign rsp_data_out  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cim_datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cim_datapath_seq
//  Description : Self-checking bench for cim_datapath_seq. Directed and random
//                commands are mirrored into a row-level reference model; the
//                transposed add is modelled as per-lane integer addition.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cim_datapath_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [1:0]  cmd_func = '0;
   logic [7:0]  cmd_a = '0, cmd_b = '0, cmd_d = '0, cmd_len = '0;
   logic [4:0]  cmd_shift = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [256];

   cim_datapath_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .sys_clk_in    (clk),
      .sys_reset_in  (rst),
      .cmd_valid_in  (cmd_valid),
      .cmd_ready_out (cmd_ready),
      .cmd_op_in     (cmd_op),
      .cmd_func_in   (cmd_func),
      .cmd_addr_a_in (cmd_a),
      .cmd_addr_b_in (cmd_b),
      .cmd_addr_d_in (cmd_d),
      .cmd_len_in    (cmd_len),
      .cmd_shift_in  (cmd_shift),
      .cmd_data_in   (cmd_data),
      .rsp_valid_out (rsp_valid),
      .rsp_ready_in  (rsp_ready),
      .rsp_data_out  (rsp_data),
      .rsp_err_out   (rsp_err),
      .busy_out      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fref(input logic [1:0] fn, input logic [31:0] x, input logic [31:0] y);
      case (fn)
         2'd0:    return x | y;
         2'd1:    return x & y;
         2'd2:    return x ^ y;
         default: return x;
      endcase
   endfunction

   // Transposed add as integer addition per lane; only the first nw result planes land.
   task automatic model_add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                            input int len, input int nw);
      logic [31:0] nr [33];
      logic [63:0] av, bv, sv;
      logic [7:0]  idx;
      for (int k = 0; k <= len; k++) nr[k] = '0;
      for (int lane = 0; lane < 32; lane++) begin
         av = '0;
         bv = '0;
         for (int k = 0; k < len; k++) begin
            idx = a + 8'(k);
            av[k] = mdl[idx][lane];
            idx = b + 8'(k);
            bv[k] = mdl[idx][lane];
         end
         sv = av + bv;
         for (int k = 0; k <= len; k++) nr[k][lane] = sv[k];
      end
      for (int k = 0; k <= len; k++) begin
         if (k < nw) begin
            idx = d + 8'(k);
            mdl[idx] = nr[k];
         end
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [1:0] fn, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] d, input logic [7:0] len,
                       input logic [4:0] sh, input logic [31:0] data);
      int n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
      end
      checks++;
      assert (n < 200) else begin
         errors++;
         $error("FAIL send_timeout observed %0d expected <200", n);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_func  = fn;
      cmd_a     = a;
      cmd_b     = b;
      cmd_d     = d;
      cmd_len   = len;
      cmd_shift = sh;
      cmd_data  = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom);
      cmd_data  = $urandom;
   endtask

   // Issue one command, update the model, and check the response or ready latency.
   task automatic run(input logic [3:0] op, input logic [1:0] fn, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] d, input logic [7:0] len,
                      input logic [4:0] sh, input logic [31:0] data, input int hold,
                      input string tag);
      logic [31:0] fv, exp_d;
      logic        exp_e;
      bit          is_rsp;
      int          exp_lat, n;
      fv = fref(fn, mdl[a], mdl[b]);
      is_rsp = 0; exp_e = 1'b0; exp_d = '0; exp_lat = 3;
      case (op)
         4'd0: begin mdl[d] = data; exp_lat = 2; end
         4'd1: begin is_rsp = 1; exp_d = mdl[a]; end
         4'd2: mdl[d] = fv;
         4'd3: mdl[d] = ~fv;
         4'd4: mdl[d] = fv << sh;
         4'd5: mdl[d] = fv >> sh;
         4'd6: begin is_rsp = 1; exp_d = {31'b0, ^fv}; end
         4'd7: begin is_rsp = 1; exp_d = {31'b0, &(fv | ~data)}; end
         4'd8: begin
            if (len == 0) begin
               is_rsp = 1; exp_e = 1'b1; exp_lat = 1;
            end else begin
               model_add(a, b, d, int'(len), int'(len) + 1);
               exp_lat = 2 * int'(len) + 2;
            end
         end
         default: begin is_rsp = 1; exp_e = 1'b1; exp_lat = 1; end
      endcase
      send(op, fn, a, b, d, len, sh, data);
      n = 0;
      if (is_rsp) begin
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
         end
         chk({tag, "_lat"}, n + 1, exp_lat);
         chk({tag, "_data"}, rsp_data, exp_d);
         chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_e});
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, "_hold_data"}, rsp_data, exp_d);
            chk({tag, "_hold_ready"}, {31'b0, cmd_ready}, 32'd0);
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         rsp_ready = 1'b0;
         chk({tag, "_rel_valid"}, {31'b0, rsp_valid}, 32'd0);
         chk({tag, "_rel_err"}, {31'b0, rsp_err}, 32'd0);
         chk({tag, "_rel_ready"}, {31'b0, cmd_ready}, 32'd1);
      end else begin
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
         end
         chk({tag, "_ready_lat"}, n + 1, exp_lat);
      end
   endtask

   task automatic wr(input logic [7:0] d, input logic [31:0] v);
      run(4'd0, 2'd0, 8'd0, 8'd0, d, 8'd0, 5'd0, v, 0, "write");
   endtask

   task automatic rd(input logic [7:0] a, input string tag);
      run(4'd1, 2'd0, a, 8'd0, 8'd0, 8'd0, 5'd0, 32'd0, 0, tag);
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  ra, rb, rdst, ln;
      for (int i = 0; i < 256; i++) mdl[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_data", rsp_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed writes and a held read
      wr(8'd3, 32'hF0F0_00FF);
      wr(8'd4, 32'h0FF0_0F0F);
      wr(8'd7, 32'hFFFF_00FF);
      wr(8'd8, 32'h0000_0007);
      run(4'd1, 2'd0, 8'd3, 8'd0, 8'd0, 8'd0, 5'd0, 32'd0, 4, "read3");
      chk("read3_const", mdl[3], 32'hF0F0_00FF);

      // Bit-line logic and post-ops
      run(4'd2, 2'd2, 8'd3, 8'd4, 8'd5, 8'd0, 5'd0, 32'd0, 0, "xor");
      rd(8'd5, "read5");
      run(4'd3, 2'd1, 8'd3, 8'd4, 8'd6, 8'd0, 5'd0, 32'd0, 0, "not_and");
      rd(8'd6, "read6");
      run(4'd4, 2'd3, 8'd3, 8'd0, 8'd9, 8'd0, 5'd4, 32'd0, 0, "shl");
      rd(8'd9, "read9");
      run(4'd5, 2'd0, 8'd3, 8'd4, 8'd10, 8'd0, 5'd7, 32'd0, 0, "shr");
      rd(8'd10, "read10");

      // Reductions
      run(4'd7, 2'd1, 8'd7, 8'd7, 8'd0, 8'd0, 5'd0, 32'hFFFF_00FF, 1, "andred_1");
      run(4'd7, 2'd1, 8'd7, 8'd7, 8'd0, 8'd0, 5'd0, 32'hFFFF_FFFF, 0, "andred_0");
      run(4'd6, 2'd3, 8'd8, 8'd0, 8'd0, 8'd0, 5'd0, 32'd0, 2, "xorred");

      // ADD, lane 0 carries 11 + 6, other lanes random
      for (int k = 0; k < 4; k++) begin
         v = $urandom; v[0] = (4'b1011 >> k) & 1'b1; wr(8'h10 + 8'(k), v);
         v = $urandom; v[0] = (4'b0110 >> k) & 1'b1; wr(8'h20 + 8'(k), v);
      end
      run(4'd8, 2'd0, 8'h10, 8'h20, 8'h30, 8'd4, 5'd0, 32'd0, 0, "add4");
      for (int k = 0; k <= 4; k++) rd(8'h30 + 8'(k), "add4_row");

      // ADD with wrapping addresses, result written in place over A
      for (int k = 0; k < 4; k++) begin
         wr(8'hFE + 8'(k), $urandom);
         wr(8'h40 + 8'(k), $urandom);
      end
      wr(8'h02, $urandom);
      run(4'd8, 2'd0, 8'hFE, 8'h40, 8'hFE, 8'd4, 5'd0, 32'd0, 0, "add_wrap");
      for (int k = 0; k <= 4; k++) rd(8'hFE + 8'(k), "add_wrap_row");

      // Illegal opcode and zero-length ADD
      wr(8'h50, 32'hA5A5_5A5A);
      run(4'd12, 2'd0, 8'h50, 8'h50, 8'h50, 8'd0, 5'd0, 32'hFFFF_FFFF, 2, "illegal12");
      run(4'd8, 2'd0, 8'h50, 8'h50, 8'h50, 8'd0, 5'd0, 32'd0, 1, "add_len0");
      rd(8'h50, "illegal_row");

      // Random single-row operations over a small row pool
      for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), $urandom);
      for (int i = 0; i < 40; i++) begin
         run(4'($urandom_range(0, 7)), 2'($urandom), 8'h80 + 8'($urandom_range(0, 7)),
             8'h80 + 8'($urandom_range(0, 7)), 8'h80 + 8'($urandom_range(0, 7)),
             8'd0, 5'($urandom), $urandom, $urandom_range(0, 2), "rand_op");
      end
      for (int i = 0; i < 8; i++) rd(8'h80 + 8'(i), "rand_row");

      // Random-length ADDs, alternating separate and in-place destinations
      for (int t = 0; t < 4; t++) begin
         ln = 8'($urandom_range(1, 8));
         ra = 8'h90; rb = 8'hA0;
         rdst = (t % 2 == 0) ? 8'hB0 : ra;
         for (int k = 0; k < 9; k++) begin
            wr(ra + 8'(k), $urandom);
            wr(rb + 8'(k), $urandom);
         end
         run(4'd8, 2'd0, ra, rb, rdst, ln, 5'd0, 32'd0, 0, "rand_add");
         for (int k = 0; k <= int'(ln); k++) rd(rdst + 8'(k), "rand_add_row");
      end

      // Reset during ADD while plane k=2 is about to be written
      for (int k = 0; k < 7; k++) begin
         wr(8'hC0 + 8'(k), 32'hDEAD_BEEF ^ 32'(k));
         wr(8'hD0 + 8'(k), $urandom);
         wr(8'hE0 + 8'(k), $urandom);
      end
      model_add(8'hD0, 8'hE0, 8'hC0, 6, 2);
      send(4'd8, 2'd0, 8'hD0, 8'hE0, 8'hC0, 8'd6, 5'd0, 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) rd(8'hC0 + 8'(k), "abort_row");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cim_datapath_seq.md
Name: cim_datapath_seq

Overview:
- Parametrised compute-in-memory datapath with its own bit-line memory array and a command/response handshake front end.
- Executes dual-row bit-line logic (OR/AND/XOR/pass), unary/shift post-ops, masked reductions and multi-cycle bit-serial transposed addition across row sequences.
- Sits between the instruction/control front end and the memory macro; replaces the fixed 32-bit single-row datapath with a width- and depth-generic, FSM-sequenced engine.

Parameters:
- DATA_WIDTH, 32: bit-lines per row (word width).
- ADDR_WIDTH, 8: row address width; DEPTH = 2**ADDR_WIDTH rows.
- SHIFT_WIDTH, $clog2(DATA_WIDTH): shift amount width (derived, not overridden).

Ports:
- sys_clk_in  in  1  system clock
- sys_reset_in  in  1  synchronous active-high reset
- cmd_valid_in  in  1  command valid
- cmd_ready_out  out  1  engine idle, command accepted when valid&ready
- cmd_op_in  in  4  opcode (see Behaviour)
- cmd_func_in  in  2  bit-line function: 0 OR, 1 AND, 2 XOR, 3 pass row A
- cmd_addr_a_in  in  ADDR_WIDTH  operand row A / base A
- cmd_addr_b_in  in  ADDR_WIDTH  operand row B / base B
- cmd_addr_d_in  in  ADDR_WIDTH  destination row / base D
- cmd_len_in  in  ADDR_WIDTH  ADD bit count L
- cmd_shift_in  in  SHIFT_WIDTH  shift amount
- cmd_data_in  in  DATA_WIDTH  write data (WRITE) or lane mask (ANDRED)
- rsp_valid_out  out  1  response valid
- rsp_ready_in  in  1  response accepted
- rsp_data_out  out  DATA_WIDTH  response data
- rsp_err_out  out  1  illegal command flag, qualified by rsp_valid_out
- busy_out  out  1  ~cmd_ready_out

Behaviour:
- Reset: cmd_ready_out=1, rsp_valid_out=0, rsp_data_out=0, rsp_err_out=0, busy_out=0, carry register=0, FSM=IDLE. Memory contents not cleared. Reset mid-operation aborts: no further writes, pending response dropped.
- Memory: single internal array, two read ports, one write port, 1-cycle registered read latency.
- F(A,B) per lane from cmd_func_in; all fields latched at accept.
- Opcodes: 0 WRITE mem[D]=data; 1 READ rsp=mem[A]; 2 LOGIC mem[D]=F; 3 NOT mem[D]=~F; 4 SHL mem[D]=F<<shift; 5 SHR mem[D]=F>>shift (logical, zero fill); 6 XORRED rsp={0,^F}; 7 ANDRED rsp={0,&(F|~mask)}; 8 ADD; 9-15 illegal.
- FSM states: IDLE, RD, EX, CARRY, RSP.
- IDLE: ready=1; accept at edge T -> RD (WRITE: performs write in RD, returns to IDLE; ready again T+2). Illegal op or ADD with L=0 -> RSP directly with rsp_err_out=1, rsp_data_out=0, no memory access.
- RD (T+1): drive read addresses. EX (T+2): compute on read data; writeback ops write at this edge and return to IDLE (ready at T+3). Response ops load rsp_data_out -> RSP; rsp_valid_out high from T+3.
- RSP: hold data/err stable until rsp_valid_out&rsp_ready_in; then valid=0, err=0, -> IDLE (ready next cycle). No new command accepted while in RSP.
- ADD (transposed, bit-plane k at rows A+k, B+k): carry cleared at accept. Per k=0..L-1: RD reads A+k, B+k; EX writes D+k = A^B^carry, carry = (A&B)|((A^B)&carry). After k=L-1 -> CARRY: write D+L = carry, -> IDLE. Total 2L+1 cycles after accept; ready at T+2L+2.
- Address arithmetic modulo DEPTH (wraps). Overlap of D with A/B is legal: plane k read before plane k written.
- cmd_ready_out and busy_out are registered state decodes; no combinational path from cmd_valid_in or rsp_ready_in to any output.

Test Plan:
- Reset, WRITE row3=0xF0F0_00FF, row4=0x0FF0_0F0F; READ A=3 -> rsp 0xF0F0_00FF at T+3, held 4 cycles with rsp_ready_in=0, released on ready.
- LOGIC func XOR A=3 B=4 D=5; READ 5 -> 0xFF00_0FF0; NOT func AND D=6 -> 0xFF0F_FFF0; SHL shift 4 func pass A=3 -> 0x0F00_0FF0.
- ANDRED A=B=7 (row7=0xFFFF_00FF) mask 0xFFFF_00FF -> rsp 1; mask 0xFFFF_FFFF -> rsp 0; XORRED of 0x0000_0007 -> rsp 1.
- ADD L=4, A=0x10, B=0x20, D=0x30, lane0 planes A=1011b(11) B=0110b(6): rows 0x30..0x34 lane0 = 17 (10001b); ready exactly 10 cycles after accept.
- ADD with A=0xFE, L=4 wraps to rows 0xFE,0xFF,0x00,0x01; D=A overlap in-place produces correct sum.
- Opcode 12 -> rsp_err_out=1, data 0, no memory change; assert reset during ADD at k=2 -> ready=1 next cycle, rows D+2.. unwritten.
